main_fsm: RTL and testbench

// - Multicycle ARMv4 main control FSM. Sequences each instruction through fetch, decode, execute, memory and writeback.
// - Produces the unconditional enables (NextPC, RegW, MemW), the flag mask (FlagW) and PCS. The downstream condition logic gates these with CondEx.
// - Adds a MemReady wait handshake on memory states and a retired-instruction counter.

---
 rtl/main_fsm_pkg.sv | 73 +++++++
 rtl/main_fsm_if.sv | 46 ++++
 rtl/main_fsm_outdec.sv | 99 +++++++++
 rtl/main_fsm.sv | 127 ++++++++++++
 tb/tb_main_fsm.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/main_fsm_pkg.sv
// -----------------------------------------------------------------------------
// main_fsm_pkg
// Shared definitions for the multicycle ARMv4 main control FSM:
//   - state_e      : 4-bit state encoding (FETCH=0 ... UNKNOWN=10; 11..15 unused)
//   - OP_* / CMD_* : instruction field constants (Instr[27:26], Instr[24:21])
//   - ADR_*, SRCA_*, SRCB_*, RES_* : datapath mux select codes
//   - ctrl_t       : control vector produced by the state decoder
//   - cmd_writes_cv: which data-processing commands update the C/V flags
// -----------------------------------------------------------------------------
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_e;

  // Instr[27:26]
  localparam logic [1:0] OP_DP     = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;
  localparam logic [1:0] OP_UNDEF  = 2'b11;

  // Instr[24:21] data-processing commands that matter to the control path
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [3:0] REG_PC = 4'd15;

  // Datapath mux selects
  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_ALU       = 1'b1;
  localparam logic       SRCA_RN       = 1'b0;
  localparam logic       SRCA_PC       = 1'b1;
  localparam logic [1:0] SRCB_RM       = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Pure state decode. fetch_strobe is the raw "this is FETCH" term; the top
  // qualifies it with MemReady to form IRWrite/NextPC.
  typedef struct packed {
    logic       fetch_strobe;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic [1:0] flag_w;
    logic       illegal;
  } ctrl_t;

  // ADD, SUB and CMP are the commands whose C/V results are architecturally
  // meaningful here; logical ops only touch N/Z.
  function automatic logic cmd_writes_cv(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/main_fsm_if.sv
// -----------------------------------------------------------------------------
// main_fsm_if
// Bundles the instruction fields / memory handshake going into the main FSM
// and the control vector coming out of it.
//   master : instruction-register / memory side (drives Op, Funct, Rd, MemReady)
//   slave  : the main FSM (drives all control outputs, InstrCount, State)
// Parameter CNT_WIDTH must match the FSM's CNT_WIDTH.
// -----------------------------------------------------------------------------
interface main_fsm_if #(
  parameter int CNT_WIDTH = 32
);
  logic [1:0]           Op;
  logic [5:0]           Funct;
  logic [3:0]           Rd;
  logic                 MemReady;

  logic                 IRWrite;
  logic                 AdrSrc;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ResultSrc;
  logic                 ALUOp;
  logic                 NextPC;
  logic                 RegW;
  logic                 MemW;
  logic                 Branch;
  logic [1:0]           FlagW;
  logic                 PCS;
  logic                 Illegal;
  logic [CNT_WIDTH-1:0] InstrCount;
  logic [3:0]           State;

  modport master (
    output Op, Funct, Rd, MemReady,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
    input  NextPC, RegW, MemW, Branch, FlagW, PCS, Illegal,
    input  InstrCount, State
  );

  modport slave (
    input  Op, Funct, Rd, MemReady,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
    output NextPC, RegW, MemW, Branch, FlagW, PCS, Illegal,
    output InstrCount, State
  );
endinterface

// File: rtl/main_fsm_outdec.sv
// -----------------------------------------------------------------------------
// main_fsm_outdec
// Combinational State -> control-vector decode (Moore part of the FSM).
// Ports:
//   state_i  in  state_e  current FSM state
//   funct_i  in  6        Instr[25:20]; [4:1]=cmd, [0]=S
//   ctrl_o   out ctrl_t   decoded control vector (fetch_strobe not yet
//                         qualified by MemReady)
// Encodings outside state_e decode to all-zero (no enables asserted); the
// next-state logic sends them to UNKNOWN on the following edge.
// -----------------------------------------------------------------------------
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  funct_i,
  output ctrl_t       ctrl_o
);

  logic [3:0] cmd;
  logic       s_bit;
  logic [1:0] exec_flag_w;

  assign cmd   = funct_i[4:1];
  assign s_bit = funct_i[0];

  // Flags are requested in the execute state; the downstream one-cycle
  // flag-write delay makes them land while the result is written back.
  assign exec_flag_w = {s_bit, s_bit & cmd_writes_cv(cmd)};

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.fetch_strobe = 1'b1;
        ctrl_o.adr_src      = ADR_PC;
        ctrl_o.alu_src_a    = SRCA_PC;
        ctrl_o.alu_src_b    = SRCB_FOUR;
        ctrl_o.alu_op       = 1'b0;
        ctrl_o.result_src   = RES_ALURESULT;
      end
      S_DECODE: begin
        // PC+8 is formed here so R15 reads see the architectural value.
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALURESULT;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = SRCA_RN;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = 1'b0;
      end
      S_MEMREAD: begin
        ctrl_o.adr_src    = ADR_ALU;
        ctrl_o.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        // MemW stays high on every wait cycle until memory accepts.
        ctrl_o.adr_src = ADR_ALU;
        ctrl_o.mem_w   = 1'b1;
      end
      S_EXECUTER: begin
        ctrl_o.alu_src_a = SRCA_RN;
        ctrl_o.alu_src_b = SRCB_RM;
        ctrl_o.alu_op    = 1'b1;
        ctrl_o.flag_w    = exec_flag_w;
      end
      S_EXECUTEI: begin
        ctrl_o.alu_src_a = SRCA_RN;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = 1'b1;
        ctrl_o.flag_w    = exec_flag_w;
      end
      S_ALUWB: begin
        // CMP only sets flags; it never writes a destination register.
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_w      = (cmd != CMD_CMP);
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = SRCA_RN;
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.alu_op     = 1'b0;
        ctrl_o.result_src = RES_ALURESULT;
        ctrl_o.branch     = 1'b1;
      end
      S_UNKNOWN: begin
        ctrl_o.illegal = 1'b1;
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// -----------------------------------------------------------------------------
// main_fsm
// Multicycle ARMv4 main control FSM: FETCH -> DECODE -> execute/memory ->
// writeback, with a MemReady wait handshake on FETCH, MEMREAD and MEMWRITE
// and a count of retired instructions.
// Parameters:
//   CNT_WIDTH       width of InstrCount (wraps modulo 2^CNT_WIDTH)
//   ILLEGAL_STICKY  1: UNKNOWN held until reset; 0: UNKNOWN -> FETCH next cycle
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   bus    main_fsm_if.slave: Op/Funct/Rd/MemReady in; IRWrite, AdrSrc,
//          ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch,
//          FlagW, PCS, Illegal, InstrCount, State out
// Enables are unconditional; downstream condition logic gates them with CondEx.
// -----------------------------------------------------------------------------
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter bit ILLEGAL_STICKY = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  main_fsm_if.slave bus
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  ctrl_t                ctrl;
  logic                 i_bit;
  logic                 l_bit;
  logic                 retire;
  logic                 fetch_go;
  logic                 reg_w_type;

  assign i_bit = bus.Funct[5];
  assign l_bit = bus.Funct[0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_MEM:    state_d = S_MEMADR;
          OP_DP:     state_d = i_bit ? S_EXECUTEI : S_EXECUTER;
          OP_BRANCH: state_d = S_BRANCH;
          default:   state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = l_bit ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
      S_EXECUTER,
      S_EXECUTEI: state_d = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH:   state_d = S_FETCH;
      S_UNKNOWN:  state_d = ILLEGAL_STICKY ? S_UNKNOWN : S_FETCH;
      // Unused encodings (e.g. after an upset) are trapped as illegal.
      default:    state_d = S_UNKNOWN;
    endcase
  end

  // An instruction retires on the edge that leaves its last state for FETCH.
  // MEMWRITE only leaves once memory has accepted the store.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BRANCH: retire = 1'b1;
      S_MEMWRITE:                 retire = bus.MemReady;
      default:                    retire = 1'b0;
    endcase
  end

  assign count_d = retire ? count_q + 1'b1 : count_q;

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  main_fsm_outdec u_outdec (
    .state_i (state_q),
    .funct_i (bus.Funct),
    .ctrl_o  (ctrl)
  );

  // The register already reads FETCH while reset is low, so the only outputs
  // that need explicit suppression are the MemReady-qualified fetch strobes.
  assign fetch_go = ctrl.fetch_strobe & bus.MemReady & reset;

  // Instructions that can target a register: data-processing ops and loads.
  assign reg_w_type = (bus.Op == OP_DP) || ((bus.Op == OP_MEM) && l_bit);

  assign bus.IRWrite    = fetch_go;
  assign bus.NextPC     = fetch_go;
  assign bus.AdrSrc     = ctrl.adr_src;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ResultSrc  = ctrl.result_src;
  assign bus.ALUOp      = ctrl.alu_op;
  assign bus.RegW       = ctrl.reg_w;
  assign bus.MemW       = ctrl.mem_w;
  assign bus.Branch     = ctrl.branch;
  assign bus.FlagW      = ctrl.flag_w;
  assign bus.Illegal    = ctrl.illegal;
  assign bus.PCS        = ((bus.Rd == REG_PC) && reg_w_type) || (bus.Op == OP_BRANCH);
  assign bus.InstrCount = count_q;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_main_fsm.sv
`timescale 1ns/1ps
// Directed bench for main_fsm. Every cycle of every instruction is queued with
// its expected state, control vector and count; the queue is then drained one
// clock at a time and compared against the DUT (dut0: CNT_WIDTH=4, sticky
// UNKNOWN). dut1 (CNT_WIDTH=32, non-sticky) sees the same inputs and is
// checked on selected records.
module tb_main_fsm;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECR    = 4'd6;
  localparam logic [3:0] ST_EXECI    = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_BRANCH   = 4'd9;
  localparam logic [3:0] ST_UNKNOWN  = 4'd10;

  typedef struct packed {
    logic       irw;
    logic       adr;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       aluop;
    logic       npc;
    logic       regw;
    logic       memw;
    logic       br;
    logic [1:0] flagw;
    logic       pcs;
    logic       ill;
  } cv_t;

  typedef struct {
    string       tag;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ev;
    logic [15:0] km;
    logic [3:0]  cnt;
    bit          chk1;
    logic [3:0]  st1;
    logic        ill1;
    logic [31:0] cnt1;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       mem_ready;

  int checks = 0;
  int errors = 0;

  rec_t       sb[$];
  logic [1:0] cur_op;
  logic [5:0] cur_f;
  logic [3:0] cur_rd;
  logic [3:0] exp_cnt;

  always #5 clk = ~clk;

  main_fsm_if #(.CNT_WIDTH(4))  if0 ();
  main_fsm_if #(.CNT_WIDTH(32)) if1 ();

  assign if0.Op = op;  assign if0.Funct = funct;  assign if0.Rd = rd;  assign if0.MemReady = mem_ready;
  assign if1.Op = op;  assign if1.Funct = funct;  assign if1.Rd = rd;  assign if1.MemReady = mem_ready;

  main_fsm #(.CNT_WIDTH(4), .ILLEGAL_STICKY(1'b1)) dut0 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if0.slave)
  );

  main_fsm #(.CNT_WIDTH(32), .ILLEGAL_STICKY(1'b0)) dut1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if1.slave)
  );

  // Expected control vector and care-mask for a state, from the output table.
  // Enables and PCS are always checked; mux selects only where defined.
  function automatic void expect_ctrl(input logic [3:0] st, input logic [1:0] o,
                                      input logic [5:0] f, input logic [3:0] r,
                                      input logic mr, output logic [15:0] ev,
                                      output logic [15:0] km);
    cv_t        e;
    cv_t        k;
    logic [3:0] cmd;
    logic [1:0] fw;
    cmd = f[4:1];
    fw  = {f[0], f[0] & ((cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010))};
    e = '0;
    k = '0;
    k.irw = 1'b1; k.npc = 1'b1; k.regw = 1'b1; k.memw = 1'b1; k.br = 1'b1;
    k.flagw = 2'b11; k.pcs = 1'b1; k.ill = 1'b1;
    e.pcs = ((r == 4'd15) && ((o == 2'b00) || ((o == 2'b01) && f[0]))) || (o == 2'b10);
    case (st)
      ST_FETCH: begin
        e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10; e.irw = mr; e.npc = mr;
        k.adr = 1'b1; k.srca = 1'b1; k.srcb = 2'b11; k.res = 2'b11; k.aluop = 1'b1;
      end
      ST_DECODE: begin
        e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10;
        k.srca = 1'b1; k.srcb = 2'b11; k.res = 2'b11;
      end
      ST_MEMADR: begin
        e.srcb = 2'b01;
        k.srca = 1'b1; k.srcb = 2'b11; k.aluop = 1'b1;
      end
      ST_MEMREAD: begin
        e.adr = 1'b1;
        k.adr = 1'b1; k.res = 2'b11;
      end
      ST_MEMWB: begin
        e.res = 2'b01; e.regw = 1'b1;
        k.res = 2'b11;
      end
      ST_MEMWRITE: begin
        e.adr = 1'b1; e.memw = 1'b1;
        k.adr = 1'b1;
      end
      ST_EXECR, ST_EXECI: begin
        e.srcb = (st == ST_EXECI) ? 2'b01 : 2'b00; e.aluop = 1'b1; e.flagw = fw;
        k.srca = 1'b1; k.srcb = 2'b11; k.aluop = 1'b1;
      end
      ST_ALUWB: begin
        e.regw = (cmd != 4'b1010);
        k.res = 2'b11;
      end
      ST_BRANCH: begin
        e.srcb = 2'b01; e.res = 2'b10; e.br = 1'b1;
        k.srca = 1'b1; k.srcb = 2'b11; k.aluop = 1'b1; k.res = 2'b11;
      end
      ST_UNKNOWN: e.ill = 1'b1;
      default: e = '0;
    endcase
    ev = e;
    km = k;
  endfunction

  function automatic logic [15:0] obs0();
    return {if0.IRWrite, if0.AdrSrc, if0.ALUSrcA, if0.ALUSrcB, if0.ResultSrc, if0.ALUOp,
            if0.NextPC, if0.RegW, if0.MemW, if0.Branch, if0.FlagW, if0.PCS, if0.Illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
    cur_op = o; cur_f = f; cur_rd = r;
  endtask

  task automatic push(input string tag, input logic [3:0] st, input logic mr,
                      input bit chk1 = 1'b0, input logic [3:0] st1 = 4'd0,
                      input logic ill1 = 1'b0, input logic [31:0] cnt1 = 32'd0);
    rec_t        r;
    logic [15:0] ev;
    logic [15:0] km;
    expect_ctrl(st, cur_op, cur_f, cur_rd, mr, ev, km);
    r.tag = tag; r.op = cur_op; r.funct = cur_f; r.rd = cur_rd; r.mr = mr;
    r.st = st; r.ev = ev; r.km = km; r.cnt = exp_cnt;
    r.chk1 = chk1; r.st1 = st1; r.ill1 = ill1; r.cnt1 = cnt1;
    sb.push_back(r);
  endtask

  // Four-cycle data-processing instruction, retired on leaving ALUWB.
  task automatic queue_dp(input string tag, input logic [3:0] exec_st);
    push({tag, "/fetch"},  ST_FETCH,  1'b1);
    push({tag, "/decode"}, ST_DECODE, 1'b1);
    push({tag, "/exec"},   exec_st,   1'b1);
    push({tag, "/aluwb"},  ST_ALUWB,  1'b1);
    exp_cnt = exp_cnt + 4'd1;
  endtask

  // Drain the scoreboard: apply one record per cycle at the falling edge and
  // compare 1 ns later, well clear of the rising edge.
  task automatic run();
    rec_t r;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(negedge clk);
      op = r.op; funct = r.funct; rd = r.rd; mem_ready = r.mr;
      #1;
      chk({r.tag, "/state"}, 32'(if0.State), 32'(r.st));
      chk({r.tag, "/ctrl"},  32'(obs0() & r.km), 32'(r.ev & r.km));
      chk({r.tag, "/count"}, 32'(if0.InstrCount), 32'(r.cnt));
      if (r.chk1) begin
        chk({r.tag, "/dut1_state"},   32'(if1.State), 32'(r.st1));
        chk({r.tag, "/dut1_illegal"}, 32'(if1.Illegal), 32'(r.ill1));
        chk({r.tag, "/dut1_count"},   if1.InstrCount, r.cnt1);
      end
    end
  endtask

  // Pull reset low mid-cycle with MemReady high: both FSMs must show FETCH
  // with the fetch strobes suppressed, zero count and no Illegal.
  task automatic check_reset(input string tag);
    logic [15:0] ev;
    logic [15:0] km;
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    expect_ctrl(ST_FETCH, op, funct, rd, 1'b0, ev, km);
    chk({tag, "/state"},        32'(if0.State), 32'(ST_FETCH));
    chk({tag, "/ctrl"},         32'(obs0() & km), 32'(ev & km));
    chk({tag, "/count"},        32'(if0.InstrCount), 32'd0);
    chk({tag, "/dut1_state"},   32'(if1.State), 32'(ST_FETCH));
    chk({tag, "/dut1_illegal"}, 32'(if1.Illegal), 32'd0);
    chk({tag, "/dut1_count"},   if1.InstrCount, 32'd0);
    exp_cnt = 4'd0;
    // Release with MemReady low so the next edge leaves FETCH in place.
    mem_ready = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1;
    op = 2'b00; funct = 6'b0; rd = 4'd0;
    exp_cnt = 4'd0;
    set_instr(2'b00, 6'b0, 4'd0);

    check_reset("reset_init");

    // ADD R1,R2,R3 with one stalled fetch cycle
    set_instr(2'b00, 6'b001000, 4'd1);
    push("add/fetch_wait", ST_FETCH, 1'b0);
    queue_dp("add", ST_EXECR);

    // SUBS R2,R2,#imm
    set_instr(2'b00, 6'b100101, 4'd2);
    queue_dp("subs_imm", ST_EXECI);

    // CMP R0,R1
    set_instr(2'b00, 6'b010101, 4'd0);
    queue_dp("cmp", ST_EXECR);

    // LDR with three MemReady=0 cycles in MEMREAD (8 cycles total)
    set_instr(2'b01, 6'b011001, 4'd3);
    push("ldr/fetch",   ST_FETCH,   1'b1);
    push("ldr/decode",  ST_DECODE,  1'b1);
    push("ldr/memadr",  ST_MEMADR,  1'b1);
    push("ldr/wait1",   ST_MEMREAD, 1'b0);
    push("ldr/wait2",   ST_MEMREAD, 1'b0);
    push("ldr/wait3",   ST_MEMREAD, 1'b0);
    push("ldr/memread", ST_MEMREAD, 1'b1);
    push("ldr/memwb",   ST_MEMWB,   1'b1);
    exp_cnt = exp_cnt + 4'd1;

    // STR with two MemReady=0 cycles in MEMWRITE
    set_instr(2'b01, 6'b011000, 4'd3);
    push("str/fetch",  ST_FETCH,    1'b1);
    push("str/decode", ST_DECODE,   1'b1);
    push("str/memadr", ST_MEMADR,   1'b1);
    push("str/wait1",  ST_MEMWRITE, 1'b0);
    push("str/wait2",  ST_MEMWRITE, 1'b0);
    push("str/write",  ST_MEMWRITE, 1'b1);
    exp_cnt = exp_cnt + 4'd1;

    // B
    set_instr(2'b10, 6'b101000, 4'd0);
    push("b/fetch",  ST_FETCH,  1'b1);
    push("b/decode", ST_DECODE, 1'b1);
    push("b/branch", ST_BRANCH, 1'b1);
    exp_cnt = exp_cnt + 4'd1;

    // ADD PC,... (Rd=15) -> PCS
    set_instr(2'b00, 6'b001000, 4'd15);
    queue_dp("add_pc", ST_EXECR);
    run();

    // Op=11: dut0 sticks in UNKNOWN, dut1 returns to FETCH without retiring.
    set_instr(2'b11, 6'b000000, 4'd0);
    push("undef/fetch",  ST_FETCH,  1'b1);
    push("undef/decode", ST_DECODE, 1'b1);
    push("undef/hold0", ST_UNKNOWN, 1'b1, 1'b1, ST_UNKNOWN, 1'b1, 32'd7);
    push("undef/hold1", ST_UNKNOWN, 1'b1, 1'b1, ST_FETCH,   1'b0, 32'd7);
    for (int i = 2; i < 20; i++) push($sformatf("undef/hold%0d", i), ST_UNKNOWN, 1'b1);
    run();

    check_reset("reset_mid");

    // Retire 17 ADDs: count runs 0..15, wraps to 0, then reaches 1.
    set_instr(2'b00, 6'b001000, 4'd1);
    for (int i = 0; i < 17; i++) queue_dp($sformatf("wrap%0d", i), ST_EXECR);
    push("after_wrap/fetch", ST_FETCH, 1'b0);
    run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
